// File: rtl/keystream_if.sv
// keystream_if
// Bundles the beat-input and block-output handshakes of the keystream
// assembler.
//   in_data/in_valid/in_last/in_ready  : word stream from the keystream source
//   out_block/out_count/out_last       : head block presented to the consumer
//   out_valid/out_ready                : block handshake
//   used                               : number of committed slots
// Modports: master = source/consumer side, slave = assembler side.
interface keystream_if #(
    parameter int DATA_W          = 8,
    parameter int WORDS_PER_BLOCK = 64,
    parameter int NUM_SLOTS       = 2
);
    localparam int BLK_W  = WORDS_PER_BLOCK * DATA_W;
    localparam int CNT_W  = $clog2(WORDS_PER_BLOCK + 1);
    localparam int USED_W = $clog2(NUM_SLOTS + 1);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [BLK_W-1:0]  out_block;
    logic [CNT_W-1:0]  out_count;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [USED_W-1:0] used;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_block, out_count, out_last, out_valid, used
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_block, out_count, out_last, out_valid, used
    );
endinterface

// File: rtl/keystream_assembler.sv
// keystream_assembler
// Packs a stream of DATA_W-bit keystream words into blocks of WORDS_PER_BLOCK
// words held in a ring of NUM_SLOTS slots. A slot commits when its last word
// is written or when a beat carries in_last; committed slots are presented
// head-first to the consumer.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : keystream_if.slave (input stream, output block, used count)
module keystream_assembler #(
    parameter int DATA_W          = 8,
    parameter int WORDS_PER_BLOCK = 64,
    parameter int NUM_SLOTS       = 2
) (
    input logic        clk,
    input logic        rst,
    keystream_if.slave bus
);
    localparam int BLK_W  = WORDS_PER_BLOCK * DATA_W;
    localparam int CNT_W  = $clog2(WORDS_PER_BLOCK + 1);
    localparam int PTR_W  = $clog2(NUM_SLOTS);
    localparam int USED_W = $clog2(NUM_SLOTS + 1);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_FILLING = 2'd1,
        ST_STALL   = 2'd2
    } state_t;

    logic [BLK_W-1:0]  slot_data_q  [NUM_SLOTS];
    logic [BLK_W-1:0]  slot_data_d  [NUM_SLOTS];
    logic [CNT_W-1:0]  slot_count_q [NUM_SLOTS];
    logic [CNT_W-1:0]  slot_count_d [NUM_SLOTS];
    logic              slot_last_q  [NUM_SLOTS];
    logic              slot_last_d  [NUM_SLOTS];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
    logic [USED_W-1:0] used_q, used_d;
    state_t            state_q, state_d;

    logic in_ready_s;
    logic out_valid_s;
    logic accept_s;
    logic commit_s;
    logic pop_s;

    // Wrap a slot pointer around the ring.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(NUM_SLOTS - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Handshake decode; in_ready depends only on registered occupancy.
    always_comb begin
        in_ready_s  = (used_q < USED_W'(NUM_SLOTS));
        out_valid_s = (used_q != {USED_W{1'b0}});
        accept_s    = bus.in_valid && in_ready_s;
        commit_s    = accept_s &&
                      (bus.in_last || (wr_idx_q == CNT_W'(WORDS_PER_BLOCK - 1)));
        pop_s       = out_valid_s && bus.out_ready;
    end

    // Slot storage next state: clear the popped slot, then store the beat.
    // The popped slot and the slot being written can never coincide, since
    // a pop needs used > 0 and a write needs used < NUM_SLOTS.
    always_comb begin
        slot_data_d  = slot_data_q;
        slot_count_d = slot_count_q;
        slot_last_d  = slot_last_q;
        if (pop_s) begin
            slot_data_d[rd_ptr_q]  = {BLK_W{1'b0}};
            slot_count_d[rd_ptr_q] = {CNT_W{1'b0}};
            slot_last_d[rd_ptr_q]  = 1'b0;
        end else begin
            slot_data_d[rd_ptr_q]  = slot_data_q[rd_ptr_q];
        end
        if (accept_s) begin
            slot_data_d[wr_ptr_q][wr_idx_q * DATA_W +: DATA_W] = bus.in_data;
        end else begin
            slot_data_d[wr_ptr_q] = slot_data_d[wr_ptr_q];
        end
        if (commit_s) begin
            slot_count_d[wr_ptr_q] = wr_idx_q + CNT_W'(1);
            slot_last_d[wr_ptr_q]  = bus.in_last;
        end else begin
            slot_count_d[wr_ptr_q] = slot_count_d[wr_ptr_q];
        end
    end

    // Pointer, word index and occupancy next state.
    always_comb begin
        wr_ptr_d = commit_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        if (commit_s) begin
            wr_idx_d = {CNT_W{1'b0}};
        end else if (accept_s) begin
            wr_idx_d = wr_idx_q + CNT_W'(1);
        end else begin
            wr_idx_d = wr_idx_q;
        end
        // Commit and pop together leave occupancy unchanged.
        case ({commit_s, pop_s})
            2'b10:   used_d = used_q + USED_W'(1);
            2'b01:   used_d = used_q - USED_W'(1);
            default: used_d = used_q;
        endcase
    end

    // Write FSM next state; STALL whenever the ring becomes full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL, ST_FILLING: begin
                if (used_d == USED_W'(NUM_SLOTS)) begin
                    state_d = ST_STALL;
                end else if (commit_s) begin
                    state_d = ST_FILL;
                end else if (accept_s) begin
                    state_d = ST_FILLING;
                end else begin
                    state_d = state_q;
                end
            end
            ST_STALL: begin
                if (pop_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_data_q[i]  <= {BLK_W{1'b0}};
                slot_count_q[i] <= {CNT_W{1'b0}};
                slot_last_q[i]  <= 1'b0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_idx_q <= {CNT_W{1'b0}};
            used_q   <= {USED_W{1'b0}};
            state_q  <= ST_FILL;
        end else begin
            slot_data_q  <= slot_data_d;
            slot_count_q <= slot_count_d;
            slot_last_q  <= slot_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_idx_q     <= wr_idx_d;
            used_q       <= used_d;
            state_q      <= state_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_block = slot_data_q[rd_ptr_q];
    assign bus.out_count = slot_count_q[rd_ptr_q];
    assign bus.out_last  = slot_last_q[rd_ptr_q];
    assign bus.used      = used_q;
endmodule

// File: tb/tb_keystream_assembler.sv
// tb_keystream_assembler
// Directed bench for keystream_assembler with default parameters
// (8-bit words, 64 words per block, 2 slots).
module tb_keystream_assembler;
    localparam int DW    = 8;
    localparam int WPB   = 64;
    localparam int NS    = 2;
    localparam int BLK_W = WPB * DW;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [BLK_W-1:0] exp_blk;

    keystream_if #(.DATA_W(DW), .WORDS_PER_BLOCK(WPB), .NUM_SLOTS(NS)) bus ();

    keystream_assembler #(.DATA_W(DW), .WORDS_PER_BLOCK(WPB), .NUM_SLOTS(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BLK_W-1:0] obs,
                         input logic [BLK_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
    endtask

    task automatic drop();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", BLK_W'(bus.out_valid), BLK_W'(0));
        check("rst_in_ready", BLK_W'(bus.in_ready), BLK_W'(1));
        check("rst_used", BLK_W'(bus.used), BLK_W'(0));
        check("rst_block", bus.out_block, BLK_W'(0));
        check("rst_count", BLK_W'(bus.out_count), BLK_W'(0));
        check("rst_last", BLK_W'(bus.out_last), BLK_W'(0));

        // out_ready with nothing presented is ignored
        pop();
        check("idle_pop_used", BLK_W'(bus.used), BLK_W'(0));

        // Full block 0x00..0x3F
        for (int i = 0; i < WPB - 1; i++) beat(8'(i), 1'b0);
        check("pre_commit_valid", BLK_W'(bus.out_valid), BLK_W'(0));
        beat(8'h3F, 1'b0);
        drop();
        check("full_valid", BLK_W'(bus.out_valid), BLK_W'(1));
        check("full_count", BLK_W'(bus.out_count), BLK_W'(64));
        check("full_last", BLK_W'(bus.out_last), BLK_W'(0));
        check("full_in_ready", BLK_W'(bus.in_ready), BLK_W'(1));
        check("full_used", BLK_W'(bus.used), BLK_W'(1));
        for (int i = 0; i < WPB; i++) exp_blk[i*DW +: DW] = 8'(i);
        check("full_block", bus.out_block, exp_blk);
        check("full_word5", BLK_W'(bus.out_block[5*DW +: DW]), BLK_W'(8'h05));
        tick();
        tick();
        tick();
        check("hold_block", bus.out_block, exp_blk);
        check("hold_count", BLK_W'(bus.out_count), BLK_W'(64));
        pop();
        check("pop_used", BLK_W'(bus.used), BLK_W'(0));
        check("pop_valid", BLK_W'(bus.out_valid), BLK_W'(0));
        check("pop_cleared", bus.out_block, BLK_W'(0));

        // 128 zero beats fill both slots
        for (int i = 0; i < 2 * WPB; i++) beat(8'h00, 1'b0);
        check("zeros_used", BLK_W'(bus.used), BLK_W'(2));
        check("zeros_in_ready", BLK_W'(bus.in_ready), BLK_W'(0));
        beat(8'h55, 1'b1);
        drop();
        check("stall_used", BLK_W'(bus.used), BLK_W'(2));
        check("stall_in_ready", BLK_W'(bus.in_ready), BLK_W'(0));
        check("zeros_blk0", bus.out_block, BLK_W'(0));
        check("zeros_cnt0", BLK_W'(bus.out_count), BLK_W'(64));
        pop();
        check("zeros_used1", BLK_W'(bus.used), BLK_W'(1));
        check("zeros_in_ready1", BLK_W'(bus.in_ready), BLK_W'(1));
        check("zeros_blk1", bus.out_block, BLK_W'(0));
        check("zeros_cnt1", BLK_W'(bus.out_count), BLK_W'(64));
        check("zeros_last1", BLK_W'(bus.out_last), BLK_W'(0));
        pop();
        check("zeros_empty", BLK_W'(bus.used), BLK_W'(0));

        // Short block closed by in_last
        for (int i = 0; i < 9; i++) beat(8'hAA, 1'b0);
        beat(8'hAA, 1'b1);
        drop();
        exp_blk = '0;
        for (int i = 0; i < 10; i++) exp_blk[i*DW +: DW] = 8'hAA;
        check("short_count", BLK_W'(bus.out_count), BLK_W'(10));
        check("short_last", BLK_W'(bus.out_last), BLK_W'(1));
        check("short_block", bus.out_block, exp_blk);
        check("short_used", BLK_W'(bus.used), BLK_W'(1));

        // Commit and pop on the same edge
        beat(8'h11, 1'b0);
        beat(8'h11, 1'b0);
        bus.out_ready = 1'b1;
        beat(8'h11, 1'b1);
        bus.out_ready = 1'b0;
        drop();
        check("simul_used", BLK_W'(bus.used), BLK_W'(1));
        check("simul_count", BLK_W'(bus.out_count), BLK_W'(3));
        check("simul_last", BLK_W'(bus.out_last), BLK_W'(1));
        check("simul_block", bus.out_block, BLK_W'(24'h111111));
        pop();
        check("simul_empty", BLK_W'(bus.used), BLK_W'(0));

        // Reset mid-block discards the partial fill
        for (int i = 0; i < 30; i++) beat(8'hEE, 1'b0);
        drop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_used", BLK_W'(bus.used), BLK_W'(0));
        check("mid_rst_block", bus.out_block, BLK_W'(0));
        for (int i = 0; i < WPB; i++) beat(8'(8'h40 + i), 1'b0);
        drop();
        for (int i = 0; i < WPB; i++) exp_blk[i*DW +: DW] = 8'(8'h40 + i);
        check("after_rst_word0", BLK_W'(bus.out_block[DW-1:0]), BLK_W'(8'h40));
        check("after_rst_count", BLK_W'(bus.out_count), BLK_W'(64));
        check("after_rst_block", bus.out_block, exp_blk);
        check("after_rst_used", BLK_W'(bus.used), BLK_W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
